// File: rtl/sd_cmd_pkg.sv
// Shared types and the CRC7 helper for the SD command frame receiver.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TXB  = 3'd1,
        ST_CMD  = 3'd2,
        ST_ARG  = 3'd3,
        ST_CRC  = 3'd4,
        ST_ENDB = 3'd5
    } state_t;

    localparam int unsigned     CRC_W     = 7;
    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    // One serial step of CRC7 (x^7 + x^3 + 1), bits presented in wire order.
    function automatic logic [CRC_W-1:0] crc7_next(input logic [CRC_W-1:0] crc, input logic din);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
    endfunction

endpackage

// File: rtl/sd_frame_fifo.sv
// Small synchronous frame queue; valid/ready on the read side.
module sd_frame_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 39
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             pop
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;

    assign out_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = out_valid && out_ready;
    // A push into a full queue still succeeds when the head leaves on the same edge.
    assign wr_en     = push && (!full || pop);
    assign out_data  = mem[rd_ptr[AW-1:0]];

    // Pointer and storage update; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '{default: '0};
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/sd_cmd_frame_rx.sv
// SD-style command frame receiver: deserialise, check framing and CRC7, queue frames.
module sd_cmd_frame_rx
    import sd_cmd_pkg::*;
#(
    parameter int unsigned CMD_W        = 6,
    parameter int unsigned ARG_W        = 32,
    parameter int unsigned MSB_FIRST    = 0,
    parameter int unsigned CRC_EN       = 1,
    parameter int unsigned DROP_BAD_CRC = 1,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             spi_cs,
    input  logic             spi_di,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [CMD_W-1:0] frame_cmd,
    output logic [ARG_W-1:0] frame_arg,
    output logic             frame_crc_ok,
    output logic             busy,
    output logic             cmd_done,
    output logic             arg_done,
    output logic             err_crc,
    output logic             err_frame,
    output logic             err_overflow,
    output logic [7:0]       err_count,
    output logic [2:0]       dbg_state,
    output logic [7:0]       dbg_count
);
    localparam int unsigned FW       = CMD_W + ARG_W + 1;
    localparam logic [7:0]  CMD_LAST = 8'(CMD_W - 1);
    localparam logic [7:0]  ARG_LAST = 8'(ARG_W - 1);
    localparam logic [7:0]  CRC_LAST = 8'(CRC_W - 1);

    state_t           state;
    state_t           state_nx;
    logic [7:0]       count;
    logic [CMD_W-1:0] cmd_sr;
    logic [ARG_W-1:0] arg_sr;
    logic [CRC_W-1:0] crc_calc;
    logic [CRC_W-1:0] crc_rx;

    logic             cmd_last;
    logic             arg_last;
    logic             frame_bad;
    logic             frame_end;
    logic             crc_match;
    logic             crc_bad;
    logic             push_req;
    logic             ovf;
    logic             fifo_full;
    logic             fifo_pop;
    logic [8:0]       err_sum;
    logic [FW-1:0]    head;

    assign crc_match = (CRC_EN == 0) || (crc_rx == crc_calc);
    assign crc_bad   = frame_end && !crc_match;
    assign push_req  = frame_end && (crc_match || (DROP_BAD_CRC == 0));
    assign ovf       = push_req && fifo_full && !fifo_pop;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-edge event strobes; chip-select release aborts any frame.
    always_comb begin
        state_nx  = state;
        cmd_last  = 1'b0;
        arg_last  = 1'b0;
        frame_bad = 1'b0;
        frame_end = 1'b0;
        if (state != ST_IDLE && spi_cs) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (!spi_cs && !spi_di) state_nx = ST_TXB;
                ST_TXB: begin
                    if (spi_di) begin
                        state_nx = ST_CMD;
                    end else begin
                        state_nx  = ST_IDLE;
                        frame_bad = 1'b1;
                    end
                end
                ST_CMD: begin
                    if (count == CMD_LAST) begin
                        state_nx = ST_ARG;
                        cmd_last = 1'b1;
                    end
                end
                ST_ARG: begin
                    if (count == ARG_LAST) begin
                        state_nx = ST_CRC;
                        arg_last = 1'b1;
                    end
                end
                ST_CRC: if (count == CRC_LAST) state_nx = ST_ENDB;
                ST_ENDB: begin
                    state_nx = ST_IDLE;
                    if (spi_di) frame_end = 1'b1;
                    else        frame_bad = 1'b1;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Field shifters, bit counter and running CRC.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            cmd_sr   <= '0;
            arg_sr   <= '0;
            crc_calc <= '0;
            crc_rx   <= '0;
        end else begin
            if (state_nx != state) begin
                count <= '0;
            end else if (state == ST_CMD || state == ST_ARG || state == ST_CRC) begin
                count <= count + 8'd1;
            end
            case (state)
                // Start bit is 0 and the CRC starts at 0, so its contribution is just 0.
                ST_IDLE: crc_calc <= '0;
                ST_TXB:  crc_calc <= crc7_next(crc_calc, spi_di);
                ST_CMD: begin
                    crc_calc <= crc7_next(crc_calc, spi_di);
                    if (MSB_FIRST != 0) cmd_sr <= {cmd_sr[CMD_W-2:0], spi_di};
                    else                cmd_sr <= {spi_di, cmd_sr[CMD_W-1:1]};
                end
                ST_ARG: begin
                    crc_calc <= crc7_next(crc_calc, spi_di);
                    if (MSB_FIRST != 0) arg_sr <= {arg_sr[ARG_W-2:0], spi_di};
                    else                arg_sr <= {spi_di, arg_sr[ARG_W-1:1]};
                end
                ST_CRC:  crc_rx <= {crc_rx[CRC_W-2:0], spi_di};
                default: ;
            endcase
        end
    end

    // Saturating error accumulation; concurrent errors each count.
    always_comb begin
        err_sum = {1'b0, err_count} + 9'(crc_bad) + 9'(frame_bad) + 9'(ovf);
    end

    // Registered event pulses and error counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_done     <= 1'b0;
            arg_done     <= 1'b0;
            err_crc      <= 1'b0;
            err_frame    <= 1'b0;
            err_overflow <= 1'b0;
            err_count    <= '0;
        end else begin
            cmd_done     <= cmd_last;
            arg_done     <= arg_last;
            err_crc      <= crc_bad;
            err_frame    <= frame_bad;
            err_overflow <= ovf;
            err_count    <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
        end
    end

    sd_frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data ({crc_match, cmd_sr, arg_sr}),
        .full      (fifo_full),
        .out_valid (frame_valid),
        .out_ready (frame_ready),
        .out_data  (head),
        .pop       (fifo_pop)
    );

    assign {frame_crc_ok, frame_cmd, frame_arg} = head;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;
    assign dbg_count = count;

endmodule
